// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage followed by the MEM/WB pipeline register.
// Issues the data-cache request for loads and stores and holds it until dhit.
// Stalls the pipe while the access is outstanding, selects the writeback
// register and data, and tracks the sticky halt.
// Optional feature macro: MEM_PERF_CNT_EN builds saturating stall/access
// performance counters; without it both perf ports are tied to zero.
module mem_wb_stage #(
  parameter int WORD_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pipe_en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [WORD_W-1:0] in_alu,
  input  logic [WORD_W-1:0] in_store,
  input  logic [WORD_W-1:0] in_npc,
  input  logic              in_dREN,
  input  logic              in_dWEN,
  input  logic              in_RegWEN,
  input  logic              in_MemtoReg,
  input  logic [1:0]        in_Regdst,
  input  logic              in_jal,
  input  logic              in_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_wen,
  output logic [4:0]        wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              halt_out,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_access_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic              reqRen_q;
  logic              reqWen_q;
  logic [WORD_W-1:0] reqAddr_q;
  logic [WORD_W-1:0] reqStore_q;
  logic [WORD_W-1:0] loadBuf_q;

  logic              wbWen_q;
  logic [4:0]        wbWsel_q;
  logic [WORD_W-1:0] wbWdat_q;
  logic              halt_q;

  logic              wbWen_d;
  logic [4:0]        wbWsel_d;
  logic [WORD_W-1:0] wbWdat_d;

  logic              startReq;
  logic              memStall;
  logic              wbUpdate;
  logic              unusedInstrBits;

  // Only the register fields of the instruction word matter to this stage.
  assign unusedInstrBits = ^{in_instr[WORD_W-1:21], in_instr[10:0]};

  // A new access starts only from IDLE, for a real memory instruction, and
  // never once the core has halted. The stall covers the presentation cycle
  // plus every ACCESS cycle, and drops immediately while reset is held.
  assign startReq = nRST && (state_q == IDLE) && in_valid
                    && (in_dREN || in_dWEN) && !halt_q;
  assign memStall = startReq || (state_q == ACCESS);
  assign wbUpdate = pipe_en && !memStall;

  // Request FSM: latches the cache request on entry to ACCESS, captures the
  // load data on dhit and waits in DONE for the pipe to advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      reqRen_q   <= 1'b0;
      reqWen_q   <= 1'b0;
      reqAddr_q  <= '0;
      reqStore_q <= '0;
      loadBuf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startReq) begin
            state_q    <= ACCESS;
            reqRen_q   <= in_dREN && !in_dWEN;
            reqWen_q   <= in_dWEN;
            reqAddr_q  <= in_alu;
            reqStore_q <= in_store;
          end
        end
        ACCESS: begin
          if (dhit) begin
            state_q    <= DONE;
            loadBuf_q  <= dmemload;
            reqRen_q   <= 1'b0;
            reqWen_q   <= 1'b0;
            reqAddr_q  <= '0;
            reqStore_q <= '0;
          end
        end
        DONE: begin
          if (pipe_en) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Writeback selection: destination decode, data mux and write enable.
  // Bubbles produce an all-zero entry; $0 is never written.
  always_comb begin
    wbWsel_d = in_instr[20:16];
    wbWdat_d = in_alu;
    wbWen_d  = 1'b0;
    case (in_Regdst)
      2'b01:   wbWsel_d = in_instr[15:11];
      2'b10:   wbWsel_d = 5'd31;
      default: wbWsel_d = in_instr[20:16];
    endcase
    if (in_jal) begin
      wbWdat_d = in_npc;
    end else if (in_MemtoReg) begin
      wbWdat_d = loadBuf_q;
    end
    wbWen_d = in_RegWEN && (wbWsel_d != 5'd0) && !halt_q;
    if (!in_valid) begin
      wbWsel_d = 5'd0;
      wbWdat_d = '0;
      wbWen_d  = 1'b0;
    end
  end

  // MEM/WB latch and sticky halt: advance only when the pipe moves and no
  // access is outstanding.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wbWen_q  <= 1'b0;
      wbWsel_q <= 5'd0;
      wbWdat_q <= '0;
      halt_q   <= 1'b0;
    end else if (wbUpdate) begin
      wbWen_q  <= wbWen_d;
      wbWsel_q <= wbWsel_d;
      wbWdat_q <= wbWdat_d;
      if (in_valid && in_halt) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign dmemREN   = reqRen_q;
  assign dmemWEN   = reqWen_q;
  assign dmemaddr  = reqAddr_q;
  assign dmemstore = reqStore_q;
  assign mem_stall = memStall;
  assign wb_wen    = wbWen_q;
  assign wb_wsel   = wbWsel_q;
  assign wb_wdat   = wbWdat_q;
  assign halt_out  = halt_q;

`ifdef MEM_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

  logic [PERF_W-1:0] stallCnt_q;
  logic [PERF_W-1:0] accessCnt_q;

  // Saturating counters: stall cycles and completed ACCESS->DONE transitions.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stallCnt_q  <= '0;
      accessCnt_q <= '0;
    end else begin
      if (memStall && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + PerfOne;
      end
      if ((state_q == ACCESS) && dhit && (accessCnt_q != '1)) begin
        accessCnt_q <= accessCnt_q + PerfOne;
      end
    end
  end

  assign perf_stall_cnt  = stallCnt_q;
  assign perf_access_cnt = accessCnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_access_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized scoreboard bench for mem_wb_stage.
// The driver issues whole instructions and pushes the expected MEM/WB entry;
// a monitor pops and compares whenever the stage advances.
module tb_mem_wb_stage;

  localparam int WORD_W = 32;
  localparam int PERF_W = 32;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              pipe_en;
  logic              in_valid;
  logic [WORD_W-1:0] in_instr;
  logic [WORD_W-1:0] in_alu;
  logic [WORD_W-1:0] in_store;
  logic [WORD_W-1:0] in_npc;
  logic              in_dREN;
  logic              in_dWEN;
  logic              in_RegWEN;
  logic              in_MemtoReg;
  logic [1:0]        in_Regdst;
  logic              in_jal;
  logic              in_halt;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;
  logic              wb_wen;
  logic [4:0]        wb_wsel;
  logic [WORD_W-1:0] wb_wdat;
  logic              halt_out;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_access_cnt;

  mem_wb_stage #(.WORD_W(WORD_W), .PERF_W(PERF_W)) dut (
    .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .in_valid(in_valid),
    .in_instr(in_instr), .in_alu(in_alu), .in_store(in_store), .in_npc(in_npc),
    .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_RegWEN(in_RegWEN),
    .in_MemtoReg(in_MemtoReg), .in_Regdst(in_Regdst), .in_jal(in_jal),
    .in_halt(in_halt), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_wen(wb_wen),
    .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .halt_out(halt_out),
    .perf_stall_cnt(perf_stall_cnt), .perf_access_cnt(perf_access_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] store;
    logic [31:0] npc;
    logic        ren;
    logic        wen;
    logic        regWen;
    logic        memToReg;
    logic [1:0]  regDst;
    logic        jal;
    logic        halt;
  } op_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
  } wb_t;

  wb_t         expQ[$];
  int          errors = 0;
  int          checks = 0;
  logic        mHalted = 1'b0;
  logic [31:0] mLoadBuf = 32'd0;
  int          mStall = 0;
  int          mAccess = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveOp(input op_t op);
    in_valid    = op.valid;
    in_instr    = op.instr;
    in_alu      = op.alu;
    in_store    = op.store;
    in_npc      = op.npc;
    in_dREN     = op.ren;
    in_dWEN     = op.wen;
    in_RegWEN   = op.regWen;
    in_MemtoReg = op.memToReg;
    in_Regdst   = op.regDst;
    in_jal      = op.jal;
    in_halt     = op.halt;
  endtask

  task automatic clearInputs();
    driveOp('0);
    pipe_en  = 1'b0;
    dhit     = 1'b0;
    dmemload = 32'd0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_stall"}, mem_stall, 0);
    checkOutput({tag, "_ren"}, dmemREN, 0);
    checkOutput({tag, "_wen"}, dmemWEN, 0);
  endtask

  // Reference: the MEM/WB entry an instruction should leave, from the rules
  // for destination decode, data source, $0 suppression, bubbles and halt.
  function automatic wb_t expectedEntry(input op_t op);
    wb_t e;
    logic [4:0] dest;
    e = '0;
    if (op.regDst == 2'b01)      dest = op.instr[15:11];
    else if (op.regDst == 2'b10) dest = 5'd31;
    else                         dest = op.instr[20:16];
    if (op.valid) begin
      e.wsel = dest;
      e.wdat = op.jal ? op.npc : (op.memToReg ? mLoadBuf : op.alu);
      e.wen  = op.regWen && (dest != 5'd0) && !mHalted;
    end
    e.halt = mHalted || (op.valid && op.halt);
    return e;
  endfunction

  // Issue one instruction end to end: presentation, cache handshake with
  // waitCycles extra wait states, doneHold cycles of held pipe, then advance.
  task automatic applyStimulus(input op_t op, input int waitCycles, input int doneHold,
                               input int idleHold, input logic [31:0] loadData);
    logic isMem;
    isMem = op.valid && (op.ren || op.wen) && !mHalted;
    if (isMem) begin
      @(negedge CLK);
      driveOp(op);
      pipe_en  = 1'($urandom_range(0, 1));
      dhit     = 1'($urandom_range(0, 1));
      dmemload = $urandom;
      #1;
      checkOutput("present_stall", mem_stall, 1);
      checkOutput("present_ren", dmemREN, 0);
      checkOutput("present_wen", dmemWEN, 0);
      mStall++;
      for (int k = 0; k <= waitCycles; k++) begin
        @(negedge CLK);
        pipe_en  = 1'($urandom_range(0, 1));
        dhit     = (k == waitCycles);
        dmemload = (k == waitCycles) ? loadData : $urandom;
        #1;
        checkOutput("access_stall", mem_stall, 1);
        checkOutput("access_ren", dmemREN, op.ren && !op.wen);
        checkOutput("access_wen", dmemWEN, op.wen);
        checkOutput("access_addr", dmemaddr, op.alu);
        checkOutput("access_store", dmemstore, op.store);
        mStall++;
      end
      mAccess++;
      mLoadBuf = loadData;
      for (int k = 0; k < doneHold; k++) begin
        @(negedge CLK);
        pipe_en  = 1'b0;
        dhit     = 1'($urandom_range(0, 1));
        dmemload = $urandom;
        #1;
        checkQuiet("done_hold");
      end
    end else begin
      for (int k = 0; k < idleHold; k++) begin
        @(negedge CLK);
        driveOp(op);
        pipe_en = 1'b0;
        dhit    = 1'($urandom_range(0, 1));
        #1;
        checkQuiet("idle_hold");
      end
    end
    @(negedge CLK);
    driveOp(op);
    pipe_en  = 1'b1;
    dhit     = 1'($urandom_range(0, 1));
    dmemload = $urandom;
    #1;
    checkQuiet("advance");
    expQ.push_back(expectedEntry(op));
    if (op.valid && op.halt) mHalted = 1'b1;
  endtask

  function automatic op_t randOp();
    op_t o;
    int  kind;
    o          = '0;
    kind       = $urandom_range(0, 9);
    o.valid    = 1'b1;
    o.instr    = $urandom;
    o.alu      = $urandom;
    o.store    = $urandom;
    o.npc      = $urandom;
    o.regDst   = 2'($urandom_range(0, 3));
    if (kind <= 3) begin
      o.regWen   = 1'($urandom_range(0, 3) != 0);
      o.memToReg = 1'($urandom_range(0, 4) == 0);
    end else if (kind <= 5) begin
      o.ren = 1'b1; o.memToReg = 1'b1; o.regWen = 1'b1;
    end else if (kind == 6) begin
      o.wen = 1'b1;
    end else if (kind == 7) begin
      o.ren = 1'b1; o.wen = 1'b1;
    end else if (kind == 8) begin
      o.jal = 1'b1; o.regWen = 1'b1; o.regDst = 2'b10;
    end else begin
      o.valid  = 1'b0;
      o.ren    = 1'($urandom_range(0, 1));
      o.regWen = 1'($urandom_range(0, 1));
    end
    return o;
  endfunction

  // Monitor: whenever the stage advances, pop the next expected entry;
  // otherwise the MEM/WB outputs must hold the last entry.
  initial begin : monitorProc
    wb_t  last;
    logic fire;
    last = '0;
    forever begin
      @(negedge CLK);
      #4;
      fire = nRST && pipe_en && !mem_stall;
      @(posedge CLK);
      #1;
      if (!nRST) begin
        last = '0;
      end else begin
        if (fire) begin
          if (expQ.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL unexpected_update: stage advanced with no expected entry at %0t", $time);
          end else begin
            last = expQ.pop_front();
          end
        end
        checkOutput("wb_wen", wb_wen, last.wen);
        checkOutput("wb_wsel", wb_wsel, last.wsel);
        checkOutput("wb_wdat", wb_wdat, last.wdat);
        checkOutput("halt_out", halt_out, last.halt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    op_t op;
    clearInputs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput("rst_wb_wen", wb_wen, 0);
    checkOutput("rst_wb_wsel", wb_wsel, 0);
    checkOutput("rst_wb_wdat", wb_wdat, 0);
    checkOutput("rst_halt", halt_out, 0);
    checkQuiet("rst");
    checkOutput("rst_addr", dmemaddr, 0);
    checkOutput("rst_store", dmemstore, 0);
    checkOutput("rst_perf_stall", perf_stall_cnt, 0);
    checkOutput("rst_perf_access", perf_access_cnt, 0);

    // Reset asserted in the middle of an outstanding load.
    op = '0;
    op.valid = 1'b1; op.ren = 1'b1; op.memToReg = 1'b1; op.regWen = 1'b1;
    op.instr = 32'h8C0A0000; op.alu = 32'h00000300;
    @(negedge CLK);
    driveOp(op);
    #1;
    checkOutput("midrst_present_stall", mem_stall, 1);
    @(negedge CLK);
    #1;
    checkOutput("midrst_access_ren", dmemREN, 1);
    checkOutput("midrst_access_addr", dmemaddr, 32'h300);
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    checkQuiet("midrst");
    checkOutput("midrst_addr", dmemaddr, 0);
    checkOutput("midrst_wb_wen", wb_wen, 0);
    checkOutput("midrst_halt", halt_out, 0);
    @(negedge CLK);
    clearInputs();
    nRST = 1'b1;
    #1;
    checkQuiet("post_rst_idle");
    mStall = 0;
    mAccess = 0;

    // add $5: ALU result written to rd.
    op = '0;
    op.valid = 1'b1; op.instr = 32'h00032820; op.alu = 32'h10;
    op.regWen = 1'b1; op.regDst = 2'b01;
    applyStimulus(op, 0, 0, 0, 32'd0);

    // lw $8, 0x100 with dhit on the third ACCESS cycle.
    op = '0;
    op.valid = 1'b1; op.instr = 32'h8C080000; op.alu = 32'h100;
    op.ren = 1'b1; op.memToReg = 1'b1; op.regWen = 1'b1;
    applyStimulus(op, 2, 1, 0, 32'hDEADBEEF);
`ifdef MEM_PERF_CNT_EN
    checkOutput("lw_perf_stall", perf_stall_cnt, 32'd4);
    checkOutput("lw_perf_access", perf_access_cnt, 32'd1);
`else
    checkOutput("lw_perf_stall_off", perf_stall_cnt, 0);
    checkOutput("lw_perf_access_off", perf_access_cnt, 0);
`endif

    // sw 0x1234 to 0x200: no register write.
    op = '0;
    op.valid = 1'b1; op.instr = 32'hAC090000; op.alu = 32'h200;
    op.store = 32'h1234; op.wen = 1'b1;
    applyStimulus(op, 1, 0, 0, 32'hCAFEF00D);

    // jal: npc written to $31.
    op = '0;
    op.valid = 1'b1; op.instr = 32'h0C000010; op.npc = 32'h44;
    op.regWen = 1'b1; op.regDst = 2'b10; op.jal = 1'b1;
    applyStimulus(op, 0, 0, 1, 32'd0);

    // add $0: write suppressed.
    op = '0;
    op.valid = 1'b1; op.instr = 32'h00040020; op.alu = 32'h55;
    op.regWen = 1'b1; op.regDst = 2'b01;
    applyStimulus(op, 0, 0, 0, 32'd0);

    // Both load and store flags: the write request wins.
    op = '0;
    op.valid = 1'b1; op.instr = 32'hAC0B0000; op.alu = 32'h404;
    op.store = 32'h77; op.ren = 1'b1; op.wen = 1'b1;
    applyStimulus(op, 1, 2, 0, 32'h12345678);

    // Bubble carrying stale control bits.
    op = '0;
    op.instr = 32'hFFFFFFFF; op.alu = 32'h99; op.regWen = 1'b1;
    op.jal = 1'b1; op.npc = 32'h88; op.ren = 1'b1;
    applyStimulus(op, 0, 0, 0, 32'd0);

    for (int i = 0; i < 200; i++) begin
      applyStimulus(randOp(), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 1), $urandom);
    end

    // Halt, then a load and an add that must not take effect.
    op = '0;
    op.valid = 1'b1; op.halt = 1'b1; op.instr = 32'hFC000000;
    applyStimulus(op, 0, 0, 0, 32'd0);
    op = '0;
    op.valid = 1'b1; op.instr = 32'h8C0C0000; op.alu = 32'h500;
    op.ren = 1'b1; op.memToReg = 1'b1; op.regWen = 1'b1;
    applyStimulus(op, 0, 0, 1, 32'd0);
    op = '0;
    op.valid = 1'b1; op.instr = 32'h00003820; op.alu = 32'h66;
    op.regWen = 1'b1; op.regDst = 2'b01;
    applyStimulus(op, 0, 0, 0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(randOp(), 0, 0, 0, $urandom);
    end

    @(negedge CLK);
    clearInputs();
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 0);
`ifdef MEM_PERF_CNT_EN
    checkOutput("perf_stall", perf_stall_cnt, mStall);
    checkOutput("perf_access", perf_access_cnt, mAccess);
`else
    checkOutput("perf_stall_off", perf_stall_cnt, 0);
    checkOutput("perf_access_off", perf_access_cnt, 0);
`endif

    // Halt is cleared only by reset.
    checkOutput("halt_sticky", halt_out, 1);
    nRST = 1'b0;
    #1;
    checkOutput("final_rst_halt", halt_out, 0);
    checkOutput("final_rst_wen", wb_wen, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM latch.
- Issues the data-cache request for loads and stores, holds it until dhit, and asserts mem_stall to the hazard unit while the access is outstanding.
- Selects the writeback register and data, and latches the result for the writeback stage and the forwarding unit.
- Tracks the sticky halt.

Parameters:
WORD_W, 32, datapath/address width
PERF_W, 32, width of optional performance counters

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
pipe_en  in  1  global advance from hazard unit (ihit-qualified)
in_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
in_instr  in  WORD_W  instruction word
in_alu  in  WORD_W  ALU result / memory address
in_store  in  WORD_W  store data (rdat2)
in_npc  in  WORD_W  PC+4
in_dREN  in  1  load
in_dWEN  in  1  store
in_RegWEN  in  1  register write enable
in_MemtoReg  in  1  writeback data from memory
in_Regdst  in  2  00 rt, 01 rd, 10 r31, 11 rt
in_jal  in  1  writeback data = npc
in_halt  in  1  halt instruction
dhit  in  1  data cache done
dmemload  in  WORD_W  load data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  WORD_W  cache address
dmemstore  out  WORD_W  cache store data
mem_stall  out  1  stage busy; upstream must hold
wb_wen  out  1  registered regfile write enable
wb_wsel  out  5  registered destination register
wb_wdat  out  WORD_W  registered writeback data
halt_out  out  1  sticky halt
perf_stall_cnt  out  PERF_W  stall cycles (optional feature)
perf_access_cnt  out  PERF_W  completed accesses (optional feature)

Behaviour:
- Reset: asynchronous on nRST low, effective immediately including mid-access.
  - Every registered output is 0: wb_*, halt_out, perf_*.
  - State returns to IDLE and the request latch clears, so dmemREN, dmemWEN, dmemaddr, dmemstore and mem_stall are all 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - Condition: in_valid && (in_dREN||in_dWEN) && !halt_out.
    - When true: latch addr, store data, REN and WEN into the request register; go to ACCESS; mem_stall=1 this cycle.
    - Otherwise mem_stall=0.
  - ACCESS:
    - dmemREN/dmemWEN/dmemaddr/dmemstore are driven from the request latch; mem_stall=1.
    - On dhit: capture dmemload into load_buf and go to DONE.
    - If in_dREN and in_dWEN are both set: dmemWEN wins and dmemREN=0.
  - DONE:
    - Requests are deasserted and mem_stall=0.
    - On pipe_en: the MEM/WB latch updates using load_buf, then go to IDLE.
    - Otherwise hold DONE and load_buf indefinitely.
- Memory latency: minimum 3 cycles from presentation to MEM/WB update when dhit arrives in the first ACCESS cycle. Each extra wait cycle adds 1.
- MEM/WB latch update rule:
  - Update on pipe_en && !mem_stall; otherwise hold all wb_* values.
  - in_valid=0 at update latches a bubble: wb_wen=0, wb_wsel=0, wb_wdat=0.
- Writeback select:
  - wb_wsel comes from the Regdst decode: rt=in_instr[20:16], rd=in_instr[15:11], r31=5'd31.
  - wb_wdat = in_npc if in_jal; else load_buf if in_MemtoReg; else in_alu.
  - wb_wen = in_valid && in_RegWEN && (wsel != 0). Writes to $0 are never enabled.
- Stores: no writeback (in_RegWEN is expected 0); load_buf is still written on dhit but unused.
- pipe_en during ACCESS is ignored; the stage never advances with an outstanding request.
- dhit outside ACCESS is ignored.
- Halt:
  - halt_out sets when a valid in_halt is latched into MEM/WB and stays set until reset.
  - Once set: no new memory requests, and wb_wen is forced 0 on all later updates.

Optional Feature:
MEM_PERF_CNT_EN
- Defined:
  - perf_stall_cnt increments every cycle mem_stall=1.
  - perf_access_cnt increments on each ACCESS→DONE transition.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: both ports tied to 0; no counter flops are generated.

Test Plan:
1. Assert nRST=0 while in ACCESS with dmemREN=1 → dmemREN, mem_stall, wb_wen and halt_out are 0 immediately; after release the FSM is in IDLE.
2. add with rd=5, in_alu=0x00000010, RegWEN=1, Regdst=01, pipe_en=1 → next edge wb_wen=1, wb_wsel=5, wb_wdat=0x10; mem_stall stays 0.
3. lw with rt=8, addr 0x100, dhit on the 3rd ACCESS cycle with dmemload=0xDEADBEEF → dmemREN=1 and dmemaddr=0x100 for exactly 3 cycles, mem_stall high 4 cycles; after pipe_en, wb_wsel=8 and wb_wdat=0xDEADBEEF. With MEM_PERF_CNT_EN: stall_cnt=4, access_cnt=1.
4. sw to addr 0x200 with data 0x1234 → dmemWEN=1, dmemstore=0x1234, dmemREN=0; wb_wen=0 after update.
5. jal with npc=0x44, Regdst=10, RegWEN=1 → wb_wsel=31, wb_wdat=0x44. Separately, an add with rd=0 → wb_wen=0.
6. halt latched, then lw presented → halt_out=1 and stays 1; dmemREN never asserts; wb_wen stays 0.
